// File: rtl/prefetch_confidence_pkg.sv
// Shared prefetcher definitions.
//   - FSM state encoding for the confidence tracker (FLUSH, WARMUP, OFF, ON)
//   - window-length derivation from its log2
//   - parameter-legality check used at elaboration
package prefetch_confidence_pkg;

    localparam logic [1:0] ST_FLUSH  = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_OFF    = 2'd2;
    localparam logic [1:0] ST_ON     = 2'd3;

    function automatic int vec_size(input int log_vec_size);
        return 1 << log_vec_size;
    endfunction

    // Thresholds must leave a non-empty hysteresis band inside the window.
    function automatic bit params_legal(input int log_vec_size, input int hi_th, input int lo_th);
        return (log_vec_size >= 1) && (lo_th >= 0) && (lo_th < hi_th) &&
               (hi_th <= vec_size(log_vec_size));
    endfunction

endpackage

// File: rtl/prefetch_confidence_ones_cnt.sv
// onesCnt: combinational population count of a 2**LOG_VEC_SIZE-bit vector.
//   A    in   [0:VEC_SIZE-1]   vector to count
//   ones out  [LOG_VEC_SIZE-1:0] number of set bits, modulo VEC_SIZE
//                              (an all-ones vector wraps to 0)
module onesCnt
    import prefetch_confidence_pkg::*;
#(
    parameter int LOG_VEC_SIZE = 3
) (
    input  logic [0:vec_size(LOG_VEC_SIZE)-1] A,
    output logic [LOG_VEC_SIZE-1:0]           ones
);

    // NOTE: every variable assigned in always_comb gets a default first,
    // so no path through the block can infer a latch.
    always_comb begin
        ones = '0;
        for (int i = 0; i < vec_size(LOG_VEC_SIZE); i++) begin
            ones = ones + LOG_VEC_SIZE'(A[i]);
        end
    end

endmodule

// File: rtl/prefetch_confidence.sv
// prefetch_confidence: sliding window of the last VEC_SIZE prefetch outcomes
// with a hysteretic prefetch-enable decision.
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   evt_valid    in   outcome event offered
//   evt_ready    out  event accepted this cycle (low in FLUSH and while flush)
//   evt_hit      in   1 = prefetched line used, 0 = miss / evicted unused
//   flush        in   clear history; wins over a simultaneous event
//   hist_vec     out  registered window, index 0 = newest
//   hit_cnt      out  registered hit count 0..VEC_SIZE (one cycle behind hist_vec)
//   warm         out  window holds VEC_SIZE valid outcomes
//   prefetch_en  out  issue permitted
module prefetch_confidence
    import prefetch_confidence_pkg::*;
#(
    parameter int LOG_VEC_SIZE = 3,
    parameter int HI_TH        = 6,
    parameter int LO_TH        = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             evt_valid,
    output logic                             evt_ready,
    input  logic                             evt_hit,
    input  logic                             flush,
    output logic [0:vec_size(LOG_VEC_SIZE)-1] hist_vec,
    output logic [LOG_VEC_SIZE:0]            hit_cnt,
    output logic                             warm,
    output logic                             prefetch_en
);

    localparam int VEC_SIZE = vec_size(LOG_VEC_SIZE);
    localparam int CW       = LOG_VEC_SIZE + 1;

    localparam logic [LOG_VEC_SIZE:0] VEC_V = CW'(VEC_SIZE);
    localparam logic [LOG_VEC_SIZE:0] HI_V  = CW'(HI_TH);
    localparam logic [LOG_VEC_SIZE:0] LO_V  = CW'(LO_TH);

    if (!params_legal(LOG_VEC_SIZE, HI_TH, LO_TH)) begin : g_bad_params
        $error("prefetch_confidence: need LOG_VEC_SIZE>=1 and 0 <= LO_TH < HI_TH <= VEC_SIZE");
    end

    logic [1:0]              state;
    logic [1:0]              state_nx;
    logic [LOG_VEC_SIZE:0]   fill;
    logic [LOG_VEC_SIZE-1:0] ones;
    logic [LOG_VEC_SIZE:0]   hits;
    logic                    accept;
    logic                    clear;

    onesCnt #(.LOG_VEC_SIZE(LOG_VEC_SIZE)) u_ones_cnt (
        .A    (hist_vec),
        .ones (ones)
    );

    // onesCnt wraps to 0 on a full window; a full window is VEC_SIZE hits.
    assign hits = (&hist_vec) ? VEC_V : {1'b0, ones};

    assign evt_ready   = (state != ST_FLUSH) && !flush;
    assign accept      = evt_valid && evt_ready;
    assign clear       = flush || (state == ST_FLUSH);
    assign prefetch_en = (state == ST_ON);

    // Decisions use the window registered at the previous edge, which gives
    // hit_cnt, state and prefetch_en their constant one-cycle lag.
    always_comb begin
        state_nx = state;
        case (state)
            ST_FLUSH:  state_nx = ST_WARMUP;
            ST_WARMUP: if (fill == VEC_V) state_nx = (hits >= HI_V) ? ST_ON : ST_OFF;
            ST_OFF:    if (hits >= HI_V) state_nx = ST_ON;
            ST_ON:     if (hits <= LO_V) state_nx = ST_OFF;
            default:   state_nx = ST_FLUSH;
        endcase
        if (flush) state_nx = ST_FLUSH;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FLUSH;
            hist_vec <= '0;
            fill     <= '0;
            hit_cnt  <= '0;
            warm     <= 1'b0;
        end else begin
            state <= state_nx;
            if (clear) begin
                hist_vec <= '0;
                fill     <= '0;
                hit_cnt  <= '0;
                warm     <= 1'b0;
            end else begin
                hit_cnt <= hits;
                warm    <= (fill == VEC_V);
                if (accept) begin
                    hist_vec <= {evt_hit, hist_vec[0:VEC_SIZE-2]};
                    if (fill != VEC_V) fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule
